// File: rtl/xled_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// xled_ctrl_pkg
//   Shared definitions for the LED controller peripheral.
//   - Register indices on the 2-bit address bus.
//   - Mode codes held in CTRL[1:0].
//   - Bit position of the busy flag in the CTRL read value.
//   - Phase encoding used by the blink sequencer.
//   - Packed state struct, so checkers can bind to one signal.
// ---------------------------------------------------------------------------
package xled_ctrl_pkg;

    // Register map
    localparam logic [1:0] LED_CTRL   = 2'd0;
    localparam logic [1:0] LED_PERIOD = 2'd1;
    localparam logic [1:0] LED_DUTY   = 2'd2;
    localparam logic [1:0] LED_COUNT  = 2'd3;

    // Mode codes
    localparam logic [1:0] LED_OFF   = 2'd0;
    localparam logic [1:0] LED_ON    = 2'd1;
    localparam logic [1:0] LED_BLINK = 2'd2;
    localparam logic [1:0] LED_PWM   = 2'd3;

    // Busy flag position in the CTRL read value
    localparam int LED_BUSY_BIT = 2;

    // Blink phase. HI is the all-zero encoding, so the reset state starts
    // a fresh sequence in the high half.
    localparam logic PH_HI = 1'b0;
    localparam logic PH_LO = 1'b1;

    // Full sequencer state: the mode plus the phase within BLINK.
    typedef struct packed {
        logic [1:0] mode;
        logic       phase;
    } xled_state_t;

    // Busy means the block is doing something other than holding the LED off.
    function automatic logic mode_busy(input logic [1:0] mode);
        return mode != LED_OFF;
    endfunction

    // LED level a freshly written mode starts with. PWM starts at cnt=0,
    // so it is lit only when DUTY is non-zero.
    function automatic logic start_level(input logic [1:0] mode, input logic duty_nz);
        logic lvl;
        case (mode)
            LED_OFF:   lvl = 1'b0;
            LED_ON:    lvl = 1'b1;
            LED_BLINK: lvl = 1'b1;
            default:   lvl = duty_nz;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/xled_presc.sv
// ---------------------------------------------------------------------------
// xled_presc
//   Tick generator. Counts 0..PRESC-1 and raises tick_o while the count
//   sits at PRESC-1. A synchronous clear restarts the count at 0, so the
//   first tick after a clear lands PRESC cycles later.
//
//   Ports
//     clk     in   system clock
//     rst     in   synchronous active-high reset
//     clr_i   in   synchronous restart of the count
//     tick_o  out  one-cycle-wide tick, every PRESC cycles
//
//   With PRESC=1 the counter stays at 0 and tick_o is permanently high.
// ---------------------------------------------------------------------------
module xled_presc #(
    parameter int PRESC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [CW-1:0] LAST  = CW'(PRESC - 1);
    localparam logic [CW-1:0] P_ONE = CW'(1);

    logic [CW-1:0] presc_cnt_q;
    logic [CW-1:0] presc_cnt_d;

    assign tick_o = (presc_cnt_q == LAST);

    always_comb begin
        presc_cnt_d = presc_cnt_q + P_ONE;
        if (clr_i || tick_o) begin
            presc_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/xled_ctrl.sv
// ---------------------------------------------------------------------------
// xled_ctrl
//   Memory-mapped LED controller for the picoVersat data bus. Firmware
//   programs CTRL/PERIOD/DUTY/COUNT; the block then drives the LED on its
//   own: steady off/on, counted or endless blinking, or PWM dimming.
//
//   Ports
//     clk       in   system clock
//     rst       in   synchronous active-high reset
//     sel       in   peripheral select from the address decoder
//     we        in   write enable, qualified by sel
//     addr      in   register index (0 CTRL, 1 PERIOD, 2 DUTY, 3 COUNT)
//     data_in   in   write data; only the low CNT_W bits (2 for CTRL) are kept
//     data_out  out  read data, combinational from addr, zero when sel=0
//                    (addr 3 returns the remaining blink count)
//     led       out  registered LED drive
//     done      out  one-cycle pulse when a counted blink sequence ends
//
//   Bus handshake: there is none beyond sel/we. A write is accepted on the
//   rising edge where sel && we are high; reads are combinational and
//   have no side effects.
//
//   Assumes DATA_W > CNT_W >= 3.
// ---------------------------------------------------------------------------
module xled_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int PRESC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              led,
    output logic              done
);

    import xled_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -----------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------
    logic wr_en;
    logic ctrl_wr;

    assign wr_en   = sel & we;
    assign ctrl_wr = wr_en && (addr == LED_CTRL);

    // Upper data bits are never stored.
    logic unused_data_hi;
    assign unused_data_hi = ^data_in[DATA_W-1:CNT_W];

    // -----------------------------------------------------------------
    // Tick generator; any CTRL write restarts it so a new mode always
    // begins on a full prescaler interval.
    // -----------------------------------------------------------------
    logic tick;

    xled_presc #(
        .PRESC (PRESC)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ctrl_wr),
        .tick_o (tick)
    );

    // -----------------------------------------------------------------
    // Configuration registers
    // -----------------------------------------------------------------
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            duty_q   <= '0;
            count_q  <= '0;
        end else if (wr_en) begin
            case (addr)
                LED_PERIOD: period_q <= data_in[CNT_W-1:0];
                LED_DUTY:   duty_q   <= data_in[CNT_W-1:0];
                LED_COUNT:  count_q  <= data_in[CNT_W-1:0];
                default:    ;
            endcase
        end
    end

    // -----------------------------------------------------------------
    // Sequencer
    // -----------------------------------------------------------------
    xled_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             led_q, led_d;
    logic             done_pulse;

    // Last count value of a period, i.e. max(PERIOD,1)-1. Comparing with
    // >= (not ==) lets a PERIOD shrunk below the running count wrap on the
    // very next tick.
    logic [CNT_W-1:0] last_cnt;
    logic             wrap;

    assign last_cnt = (period_q == '0) ? '0 : (period_q - CNT_ONE);
    assign wrap     = (cnt_q >= last_cnt);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        led_d      = led_q;
        done_pulse = 1'b0;

        if (ctrl_wr) begin
            // A CTRL write always restarts, and overrides any sequence end
            // falling in the same cycle (so no done pulse then).
            state_d.mode  = data_in[1:0];
            state_d.phase = PH_HI;
            cnt_d         = '0;
            rem_d         = count_q;
            led_d         = start_level(data_in[1:0], duty_q != '0);
        end else begin
            case (state_q.mode)
                LED_OFF: led_d = 1'b0;
                LED_ON:  led_d = 1'b1;
                LED_BLINK: begin
                    if (tick) begin
                        if (wrap) begin
                            cnt_d = '0;
                            if (state_q.phase == PH_HI) begin
                                state_d.phase = PH_LO;
                            end else if (count_q == '0) begin
                                // COUNT=0 blinks forever.
                                state_d.phase = PH_HI;
                            end else if (rem_q <= CNT_ONE) begin
                                // rem can only be 0 here if COUNT was made
                                // non-zero during an endless run; end then
                                // rather than wrapping the remaining count.
                                rem_d         = '0;
                                state_d.mode  = LED_OFF;
                                state_d.phase = PH_HI;
                                done_pulse    = 1'b1;
                            end else begin
                                rem_d         = rem_q - CNT_ONE;
                                state_d.phase = PH_HI;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    led_d = (state_d.mode == LED_BLINK) && (state_d.phase == PH_HI);
                end
                default: begin
                    // PWM: the level follows the count the tick moves to.
                    if (tick) begin
                        cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
                        led_d = (cnt_d < duty_q);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '{mode: LED_OFF, phase: PH_HI};
            cnt_q   <= '0;
            rem_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    // done is taken straight from the end-of-sequence decision, so it is
    // high during the last low cycle; reset aborts without a pulse.
    assign done = done_pulse & ~rst;

    // -----------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------
    always_comb begin
        data_out = '0;
        if (sel) begin
            case (addr)
                LED_CTRL: begin
                    data_out[1:0]         = state_q.mode;
                    data_out[LED_BUSY_BIT] = mode_busy(state_q.mode);
                end
                LED_PERIOD: data_out[CNT_W-1:0] = period_q;
                LED_DUTY:   data_out[CNT_W-1:0] = duty_q;
                default:    data_out[CNT_W-1:0] = rem_q;
            endcase
        end
    end

endmodule

// File: tb/tb_xled_ctrl.sv
// ---------------------------------------------------------------------------
// tb_xled_ctrl
//   Two controllers share one bus: one with PRESC=1, one with PRESC=4.
//   A behavioural model (plain ints) predicts led, done and read data for
//   both every cycle; directed sequences add fixed expectations on top.
// ---------------------------------------------------------------------------
module tb_xled_ctrl;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] data_in = 32'd0;

    logic [1:0]  led_v;
    logic [1:0]  done_v;
    logic [31:0] dout_v [2];

    xled_ctrl #(.DATA_W(32), .CNT_W(16), .PRESC(1)) dut_p1 (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(dout_v[0]), .led(led_v[0]), .done(done_v[0])
    );

    xled_ctrl #(.DATA_W(32), .CNT_W(16), .PRESC(4)) dut_p4 (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(dout_v[1]), .led(led_v[1]), .done(done_v[1])
    );

    // ---------------------------------------------------------------
    // Scoreboard counters and checker
    // ---------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    typedef struct {
        int mode;     // 0 off, 1 on, 2 blink, 3 pwm
        bit lit_half; // blink: currently in the lit half of a blink
        int pos;      // ticks elapsed in current half / pwm position
        int pc;       // cycles since last tick
        int left;     // blinks still to finish
        int period;
        int duty;
        int count;
        bit led;
    } mdl_t;

    mdl_t m[2];
    mdl_t nxt[2];
    int   presc_of[2] = '{1, 4};

    function automatic mdl_t m_step(input mdl_t s, input int presc, input bit r,
                                    input bit wr, input logic [1:0] a,
                                    input logic [31:0] d, output bit dn);
        mdl_t n;
        bit   tick;
        bit   last;
        int   pe;
        n  = s;
        dn = 1'b0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        pe   = (s.period == 0) ? 1 : s.period;
        tick = (s.pc == presc - 1);
        last = tick && (s.pos + 1 >= pe);
        n.pc = tick ? 0 : s.pc + 1;
        if (wr && a == 2'd0) begin
            n.mode     = int'(d[1:0]);
            n.lit_half = 1'b1;
            n.pos      = 0;
            n.pc       = 0;
            n.left     = s.count;
            n.led      = (n.mode == 1) || (n.mode == 2) || (n.mode == 3 && s.duty > 0);
            return n;
        end
        if (wr && a == 2'd1) n.period = int'(d[15:0]);
        if (wr && a == 2'd2) n.duty   = int'(d[15:0]);
        if (wr && a == 2'd3) n.count  = int'(d[15:0]);
        if (s.mode == 0) n.led = 1'b0;
        if (s.mode == 1) n.led = 1'b1;
        if (s.mode == 2) begin
            if (tick) n.pos = last ? 0 : s.pos + 1;
            if (last && s.lit_half) begin
                n.lit_half = 1'b0;
            end else if (last) begin
                n.lit_half = 1'b1;
                if (s.count != 0) begin
                    n.left = (s.left <= 1) ? 0 : s.left - 1;
                    if (s.left <= 1) begin
                        n.mode = 0;
                        dn     = 1'b1;
                    end
                end
            end
            n.led = (n.mode == 2) && n.lit_half;
        end
        if (s.mode == 3 && tick) begin
            n.pos = (s.pos + 1) % pe;
            if (s.pos >= pe) n.pos = 0;
            n.led = (n.pos < s.duty);
        end
        return n;
    endfunction

    function automatic logic [31:0] m_read(input mdl_t s, input bit sl, input logic [1:0] a);
        if (!sl) return 32'd0;
        case (a)
            2'd0:    return 32'((s.mode != 0 ? 4 : 0) + s.mode);
            2'd1:    return 32'(s.period);
            2'd2:    return 32'(s.duty);
            default: return 32'(s.left);
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Driver: one bus cycle, with model comparison for both DUTs
    // ---------------------------------------------------------------
    logic        obs_led [2];
    logic        obs_done[2];
    logic [31:0] obs_dout[2];

    task automatic cycle(input bit r, input bit s, input bit w,
                         input logic [1:0] a, input logic [31:0] d);
        bit dn;
        @(negedge clk);
        rst = r; sel = s; we = w; addr = a; data_in = d;
        #1;
        for (int i = 0; i < 2; i++) begin
            obs_led[i]  = led_v[i];
            obs_done[i] = done_v[i];
            obs_dout[i] = dout_v[i];
            nxt[i] = m_step(m[i], presc_of[i], r, s && w, a, d, dn);
            check($sformatf("mdl_led_p%0d", presc_of[i]), {31'd0, obs_led[i]}, {31'd0, m[i].led});
            check($sformatf("mdl_done_p%0d", presc_of[i]), {31'd0, obs_done[i]}, {31'd0, dn});
            check($sformatf("mdl_rd%0d_p%0d", a, presc_of[i]), obs_dout[i], m_read(m[i], s, a));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) m[i] = nxt[i];
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        cycle(1'b0, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 2; i++) m[i] = '{default: 0};

        // Reset state
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check($sformatf("rst_rd%0d", a), obs_dout[0], 32'd0);
            check("rst_led", {31'd0, obs_led[0]}, 32'd0);
        end

        // Counted blink: PERIOD=3, COUNT=2
        wr(2'd1, 32'd3);
        wr(2'd3, 32'd2);
        wr(2'd0, 32'd2);
        for (int k = 1; k <= 12; k++) begin
            rd(2'd3);
            check($sformatf("blk_led_c%0d", k), {31'd0, obs_led[0]}, {31'd0, (((k - 1) / 3) % 2) == 0});
            check($sformatf("blk_done_c%0d", k), {31'd0, obs_done[0]}, {31'd0, k == 12});
            check($sformatf("blk_rem_c%0d", k), obs_dout[0], (k <= 6) ? 32'd2 : 32'd1);
        end
        rd(2'd0);
        check("blk_mode_after", obs_dout[0], 32'd0);
        check("blk_led_after", {31'd0, obs_led[0]}, 32'd0);
        rd(2'd3);
        check("blk_rem_after", obs_dout[0], 32'd0);

        // PWM, PERIOD=4
        wr(2'd1, 32'd4);
        wr(2'd2, 32'd1);
        wr(2'd0, 32'd3);
        for (int k = 1; k <= 8; k++) begin
            rd(2'd2);
            check($sformatf("pwm1_led_c%0d", k), {31'd0, obs_led[0]}, {31'd0, ((k - 1) % 4) == 0});
        end
        wr(2'd2, 32'd0);
        idle();
        for (int k = 0; k < 8; k++) begin
            idle();
            check("pwm0_led", {31'd0, obs_led[0]}, 32'd0);
        end
        wr(2'd2, 32'd9);
        idle();
        for (int k = 0; k < 8; k++) begin
            idle();
            check("pwm9_led", {31'd0, obs_led[0]}, 32'd1);
        end
        wr(2'd2, 32'd1);
        repeat (5) idle();
        wr(2'd2, 32'd3);
        repeat (8) idle();

        // PRESC=4 endless blink, PERIOD=2
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd2);
        for (int k = 1; k <= 40; k++) begin
            idle();
            check($sformatf("p4_led_c%0d", k), {31'd0, obs_led[1]}, {31'd0, (((k - 1) / 8) % 2) == 0});
            check("p4_done", {31'd0, obs_done[1]}, 32'd0);
        end

        // CTRL write in the cycle a counted blink ends
        wr(2'd1, 32'd1);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'd2);
        idle();
        check("race_led_hi", {31'd0, obs_led[0]}, 32'd1);
        wr(2'd0, 32'd1);
        check("race_done", {31'd0, obs_done[0]}, 32'd0);
        rd(2'd0);
        check("race_led_on", {31'd0, obs_led[0]}, 32'd1);
        check("race_mode", obs_dout[0], 32'd5);

        // Reset in the middle of a blink
        wr(2'd1, 32'd5);
        wr(2'd3, 32'd3);
        wr(2'd0, 32'd2);
        repeat (4) idle();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        check("rst_mid_done", {31'd0, obs_done[0]}, 32'd0);
        rd(2'd0);
        check("rst_mid_mode", obs_dout[0], 32'd0);
        check("rst_mid_led", {31'd0, obs_led[0]}, 32'd0);
        rd(2'd3);
        check("rst_mid_rem", obs_dout[0], 32'd0);

        // PERIOD=0 behaves as PERIOD=1
        wr(2'd3, 32'd2);
        wr(2'd0, 32'd2);
        for (int k = 1; k <= 5; k++) begin
            idle();
            check($sformatf("p0_led_c%0d", k), {31'd0, obs_led[0]}, {31'd0, (k <= 4) && (k % 2 == 1)});
            check($sformatf("p0_done_c%0d", k), {31'd0, obs_done[0]}, {31'd0, k == 4});
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int          op;
            logic [1:0]  a;
            logic [31:0] d;
            op = $urandom_range(0, 99);
            a  = 2'($urandom_range(0, 3));
            d  = $urandom & 32'hFFFF_0000;
            case (a)
                2'd0:    d = d | 32'($urandom_range(0, 3));
                2'd3:    d = d | 32'($urandom_range(0, 3));
                default: d = d | 32'($urandom_range(0, 6));
            endcase
            if (op < 1)       cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
            else if (op < 15) cycle(1'b0, 1'b1, 1'b1, a, d);
            else if (op < 20) cycle(1'b0, 1'b0, 1'b1, a, d);
            else              cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, a, $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
